// File: rtl/jtdsp16_pio_host_if.sv
// Bundles the DSP16 PIO pins and the host-side access port of jtdsp16_pio_host.
// The master modport is the outside world (DSP core plus host CPU); slave is the controller.
interface jtdsp16_pio_host_if;
  // DSP parallel I/O side
  logic        pods_n;
  logic        pids_n;
  logic        psel;
  logic [15:0] pbus_out;
  logic [15:0] pbus_in;
  logic        dsp_irq;
  // Host CPU side
  logic [15:0] host_din;
  logic        host_we;
  logic        host_full;
  logic        host_sel;
  logic [15:0] host_dout;
  logic [1:0]  host_valid;
  logic        host_ack;
  logic        ovf_clr;
  logic        ovf;

  modport slave (
    input  pods_n, pids_n, psel, pbus_out,
    output pbus_in, dsp_irq,
    input  host_din, host_we, host_sel, host_ack, ovf_clr,
    output host_full, host_dout, host_valid, ovf
  );

  modport master (
    output pods_n, pids_n, psel, pbus_out,
    input  pbus_in, dsp_irq,
    output host_din, host_we, host_sel, host_ack, ovf_clr,
    input  host_full, host_dout, host_valid, ovf
  );
endinterface

// File: rtl/jtdsp16_pio_host.sv
// Host-side controller for the DSP16 active-mode PIO port: a command FIFO feeding DSP input
// strobes, two output latches filled by DSP output strobes, and the pending-command interrupt.
module jtdsp16_pio_host #(
  parameter int unsigned AW = 2
) (
  input logic               clk,
  input logic               rst,
  jtdsp16_pio_host_if.slave bus
);

  localparam int unsigned Depth = 1 << AW;
  // Pointer width kept at least 1 so a single-entry FIFO still elaborates
  localparam int unsigned PW    = (AW > 0) ? AW : 1;
  localparam int unsigned CW    = AW + 1;

  logic [15:0]   mem [Depth];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          last_pods_n_q, last_pids_n_q;
  logic [15:0]   latch_q [2];
  logic [15:0]   latch_d [2];
  logic [1:0]    valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          dsp_irq_q, dsp_irq_d;

  logic          empty, full;
  logic          pods_rise, pids_rise;
  logic          pop, push, ovf_set;
  logic [2:0]    count3;
  logic [15:0]   head;

  // Strobe edge detection and FIFO control
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(Depth));
    pods_rise = bus.pods_n & ~last_pods_n_q;
    pids_rise = bus.pids_n & ~last_pids_n_q;
    pop       = pids_rise & ~bus.psel & ~empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands
    push      = bus.host_we & (~full | pop);
    ovf_set   = bus.host_we & full & ~pop;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Output latches: a capture beats a host acknowledge on the same latch
  always_comb begin
    latch_d[0] = latch_q[0];
    latch_d[1] = latch_q[1];
    valid_d    = valid_q;
    if (bus.host_ack) begin
      valid_d[bus.host_sel] = 1'b0;
    end
    if (pods_rise) begin
      latch_d[bus.psel] = bus.pbus_out;
      valid_d[bus.psel] = 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
    // Drops while the DSP is strobing an input so each pending word gets a fresh edge
    dsp_irq_d = ~empty & bus.pids_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      last_pods_n_q <= 1'b1;
      last_pids_n_q <= 1'b1;
      latch_q[0]    <= '0;
      latch_q[1]    <= '0;
      valid_q       <= '0;
      ovf_q         <= 1'b0;
      dsp_irq_q     <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      last_pods_n_q <= bus.pods_n;
      last_pids_n_q <= bus.pids_n;
      latch_q[0]    <= latch_d[0];
      latch_q[1]    <= latch_d[1];
      valid_q       <= valid_d;
      ovf_q         <= ovf_d;
      dsp_irq_q     <= dsp_irq_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.host_din;
    end
  end

  always_comb begin
    count3 = 3'(count_q);
    head   = empty ? 16'd0 : mem[rd_ptr_q];
  end

  assign bus.pbus_in    = bus.psel ? {count3, ovf_q, valid_q, 9'd0, ~empty} : head;
  assign bus.dsp_irq    = dsp_irq_q;
  assign bus.host_full  = full;
  assign bus.host_dout  = latch_q[bus.host_sel];
  assign bus.host_valid = valid_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: doc/jtdsp16_pio_host.md
Name: jtdsp16_pio_host

Overview:
- Host-side controller for the DSP16 parallel I/O port: sits between a host CPU and the DSP's active-mode PIO pins (pods_n, pids_n, psel, pbus).
- Queues host command words in a FIFO and serves them to DSP input strobes.
- Captures DSP output strobes into two per-select output latches with valid flags, and generates the DSP external interrupt while commands are pending.
- Owns the host handshake and all arbitration between host accesses and DSP strobes.

Parameters:
- AW, 2: FIFO address width; depth = 2**AW entries (1..4 supported).

Ports:
- clk, input, 1: system clock (same clock as the DSP core).
- rst, input, 1: reset, asynchronous, active-high.
- pods_n, input, 1: DSP parallel output data strobe, active low.
- pids_n, input, 1: DSP parallel input data strobe, active low.
- psel, input, 1: DSP peripheral select; 0 = data channel, 1 = status/aux channel.
- pbus_out, input, 16: data driven by the DSP; stable while pods_n is low.
- pbus_in, output, 16: data presented to the DSP.
- dsp_irq, output, 1: external interrupt request to the DSP.
- host_din, input, 16: host write data.
- host_we, input, 1: host write strobe; one push per high cycle.
- host_full, output, 1: FIFO full.
- host_sel, input, 1: selects which output latch the host reads.
- host_dout, output, 16: output latch selected by host_sel.
- host_valid, output, 2: valid flags, bit0 = latch 0, bit1 = latch 1.
- host_ack, input, 1: clears the valid flag of the latch selected by host_sel.
- ovf_clr, input, 1: clears the sticky overflow flag.
- ovf, output, 1: sticky flag, set when a push arrives while the FIFO is full.

Behaviour:
- Reset values:
  - FIFO empty, count = 0, read and write pointers = 0.
  - pbus_in = 0, dsp_irq = 0, host_full = 0, host_valid = 2'b00, ovf = 0, both latches = 0.
  - Strobe edge registers (last_pods_n, last_pids_n) reset to 1.
- Reset mid-operation: discards FIFO contents and latches immediately; no pop or capture occurs for a strobe that was in flight.
- Strobe edge detection:
  - Register pods_n and pids_n every clk.
  - Rising edge = current high and last low. Strobe edges are processed on the clk cycle where the rising edge is seen, independent of ph1.
- DSP input path:
  - pbus_in is combinational.
  - psel = 0: FIFO head word, or 0 when empty.
  - psel = 1: status word {count[2:0], ovf, host_valid[1:0], 9'd0, ~empty}; count is zero-extended to 3 bits.
  - Pop occurs on a pids_n rising edge with psel = 0 and FIFO non-empty. The pointer advances one cycle after the edge; the head stays stable for the whole low period.
  - pids_n rising edge with psel = 0 and FIFO empty: no state change; the DSP read 0.
  - psel = 1 reads never pop.
- DSP output path:
  - On a pods_n rising edge, capture pbus_out into latch[psel] and set host_valid[psel].
  - Overwriting a latch that is still valid is allowed; the newest data wins and valid stays 1.
- Host write:
  - host_we with FIFO not full: store at the write pointer, count + 1.
  - host_we with FIFO full: data dropped, ovf <= 1.
  - host_full = (count == 2**AW).
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, push+pop in the same cycle: the pop frees the slot, so the push is accepted and ovf is not set.
  - When empty, push+pop cannot coincide because a pop requires non-empty.
- Host read: host_dout = latch[host_sel], combinational.
  - host_ack clears host_valid[host_sel] next cycle.
  - A capture to the same latch in the same cycle as host_ack wins: valid stays 1.
- Overflow flag: ovf_clr clears ovf. When ovf_clr and a set event happen in the same cycle, the set wins.
- Interrupt:
  - dsp_irq (registered) = ~empty & pids_n_q, where pids_n_q is pids_n registered in the same cycle.
  - Thus irq drops while the DSP is strobing an input and rises again after the pop if data remains. This gives the DSP a fresh rising edge per pending word.
- Pointer arithmetic: pointers are AW bits and wrap modulo 2**AW. count is AW+1 bits.

Test Plan:
1. Reset, then push 16'h1234, 16'h5678 -> dsp_irq rises 1 cycle after the first push. A pids_n low pulse (4 cycles, psel = 0) shows pbus_in = 1234 and dsp_irq low. After the rising edge the head is 5678 and dsp_irq rises again.
2. Push 5 words with AW = 2 -> host_full = 1 after the 4th push; the 5th is dropped and ovf = 1. The psel = 1 status reads 16'b100_1_00_000000000_1. ovf_clr clears ovf.
3. With the FIFO full, push and pop in the same cycle -> the push is accepted, count stays 4, ovf stays 0. The data order is preserved over 4 subsequent pops.
4. pods_n pulse with psel = 1 and pbus_out = 16'hBEEF -> host_valid = 2'b10. host_sel = 1 gives host_dout = BEEF. host_ack gives host_valid = 2'b00.
5. host_ack on latch 0 in the same cycle as a pods_n rising edge with psel = 0 and data 16'h00A5 -> host_valid[0] stays 1, latch 0 = 00A5.
6. Assert rst while 3 words are queued and pids_n is low -> FIFO empties, dsp_irq = 0. The later pids_n rising edge causes no pop, and pbus_in = 0.
